// File: rtl/battleship_pkg.sv
// Shared types for the battleship board logic: resolver FSM states, operation kinds, board size.
package battleship_pkg;

    localparam int BS_CELLS = 16;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} resolver_state_t;
    typedef enum logic {OP_ARM, OP_RES} resolver_op_t;

endpackage

// File: rtl/shot_resolver_if.sv
// Request/result bundle between the game FSM and shot_resolver.
interface shot_resolver_if #(
    parameter int CELLS = 16
) ();
    localparam int CNT_W = $clog2(CELLS + 1);
    localparam int IDX_W = $clog2(CELLS);

    logic             arm;
    logic             start;
    logic [CELLS-1:0] ships;
    logic [CELLS-1:0] shots_prev;
    logic [CELLS-1:0] shots_new;
    logic             busy;
    logic             done;
    logic             ok;
    logic             hit;
    logic [IDX_W-1:0] shot_idx;
    logic             commit;
    logic [CNT_W-1:0] ships_left;
    logic             live;

    modport master (
        output arm, start, ships, shots_prev, shots_new,
        input  busy, done, ok, hit, shot_idx, commit, ships_left, live
    );

    modport slave (
        input  arm, start, ships, shots_prev, shots_new,
        output busy, done, ok, hit, shot_idx, commit, ships_left, live
    );
endinterface

// File: rtl/bs_scan_ctr.sv
// Cell index counter for the resolver scan: cleared on request, advances one cell per enabled clock.
module bs_scan_ctr #(
    parameter int CELLS = 16,
    localparam int IDX_W = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    logic [IDX_W-1:0] idx_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            idx_reg <= '0;
        end else if (en) begin
            idx_reg <= idx_reg + IDX_W'(1);
        end
    end

    assign idx  = idx_reg;
    assign last = (idx_reg == IDX_W'(CELLS - 1));
endmodule

// File: rtl/shot_resolver.sv
// Per-turn shot resolution and remaining-ship bookkeeping, scanning one cell per clock.
// Optional: define SHOT_RESOLVER_EARLY_ABORT_EN to end an illegal resolve scan early.
module shot_resolver
    import battleship_pkg::*;
#(
    parameter int CELLS = BS_CELLS
) (
    input logic           clk,
    input logic           clr,
    shot_resolver_if.slave bus
);
    localparam int CNT_W = $clog2(CELLS + 1);
    localparam int IDX_W = $clog2(CELLS);

    resolver_state_t  state_reg, state_next;
    resolver_op_t     op_reg, op_next;
    logic [CNT_W-1:0] acc_reg, acc_next;
    logic [1:0]       chg_reg, chg_next;
    logic             bad_reg, bad_next;
    logic [IDX_W-1:0] found_reg, found_next;
    logic             ok_reg, ok_next;
    logic             hit_reg, hit_next;
    logic [IDX_W-1:0] shot_idx_reg, shot_idx_next;
    logic             commit_reg, commit_next;
    logic [CNT_W-1:0] ships_left_reg, ships_left_next;

    logic             scan_clear;
    logic             scan_en;
    logic [IDX_W-1:0] idx;
    logic             last_cell;
    logic             abort;

    bs_scan_ctr #(.CELLS(CELLS)) u_scan_ctr (
        .clk   (clk),
        .srst  (clr),
        .clear (scan_clear),
        .en    (scan_en),
        .idx   (idx),
        .last  (last_cell)
    );

    // Per-cell contributions including the cell under the index this clock.
    logic             diff;
    logic [1:0]       chg_step;
    logic             bad_step;
    logic [IDX_W-1:0] found_step;
    logic [CNT_W-1:0] acc_step;
    logic             res_ok;
    logic             res_hit;

    always_comb begin
        diff       = bus.shots_new[idx] ^ bus.shots_prev[idx];
        chg_step   = (diff && chg_reg != 2'd2) ? chg_reg + 2'd1 : chg_reg;
        bad_step   = bad_reg | (diff & ~bus.shots_new[idx]);
        found_step = diff ? idx : found_reg;
        acc_step   = acc_reg + CNT_W'(bus.ships[idx]);
        res_ok     = (chg_step == 2'd1) && !bad_step;
        res_hit    = res_ok && bus.ships[found_step];
    end

`ifdef SHOT_RESOLVER_EARLY_ABORT_EN
    assign abort = (op_reg == OP_RES) && ((chg_reg == 2'd2) || bad_reg);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        acc_next        = acc_reg;
        chg_next        = chg_reg;
        bad_next        = bad_reg;
        found_next      = found_reg;
        ok_next         = ok_reg;
        hit_next        = hit_reg;
        shot_idx_next   = shot_idx_reg;
        commit_next     = 1'b0;
        ships_left_next = ships_left_reg;
        scan_clear      = 1'b0;
        scan_en         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.arm) begin
                    op_next    = OP_ARM;
                    acc_next   = '0;
                    scan_clear = 1'b1;
                    state_next = SCAN;
                end else if (bus.start) begin
                    op_next    = OP_RES;
                    chg_next   = 2'd0;
                    bad_next   = 1'b0;
                    scan_clear = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                if (op_reg == OP_ARM) begin
                    acc_next = acc_step;
                end else begin
                    chg_next   = chg_step;
                    bad_next   = bad_step;
                    found_next = found_step;
                end
                if (last_cell || abort) begin
                    state_next = DONE;
                    if (op_reg == OP_ARM) begin
                        ships_left_next = acc_step;
                        ok_next         = 1'b1;
                        hit_next        = 1'b0;
                    end else begin
                        ok_next       = res_ok;
                        hit_next      = res_hit;
                        shot_idx_next = found_step;
                        commit_next   = res_ok;
                        if (res_hit && ships_left_reg != '0) begin
                            ships_left_next = ships_left_reg - CNT_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= IDLE;
            op_reg         <= OP_ARM;
            acc_reg        <= '0;
            chg_reg        <= 2'd0;
            bad_reg        <= 1'b0;
            found_reg      <= '0;
            ok_reg         <= 1'b0;
            hit_reg        <= 1'b0;
            shot_idx_reg   <= '0;
            commit_reg     <= 1'b0;
            ships_left_reg <= '0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            acc_reg        <= acc_next;
            chg_reg        <= chg_next;
            bad_reg        <= bad_next;
            found_reg      <= found_next;
            ok_reg         <= ok_next;
            hit_reg        <= hit_next;
            shot_idx_reg   <= shot_idx_next;
            commit_reg     <= commit_next;
            ships_left_reg <= ships_left_next;
        end
    end

    assign bus.busy       = (state_reg == SCAN);
    assign bus.done       = (state_reg == DONE);
    assign bus.ok         = ok_reg;
    assign bus.hit        = hit_reg;
    assign bus.shot_idx   = shot_idx_reg;
    assign bus.commit     = commit_reg;
    assign bus.ships_left = ships_left_reg;
    assign bus.live       = (ships_left_reg != '0);
endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver (CELLS = 16): arm, hits, misses, illegal entries, sink, clr and request collisions.
module tb_shot_resolver;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    int   lat;

    always #5 clk = ~clk;

    shot_resolver_if #(.CELLS(16)) bus ();

    shot_resolver #(.CELLS(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge and wait (bounded) for done; returns edges from request to done.
    task automatic do_op(input string tag, input bit a, input bit s,
                         input logic [15:0] sh, input logic [15:0] pv, input logic [15:0] nw,
                         output int l);
        bus.ships = sh; bus.shots_prev = pv; bus.shots_new = nw;
        bus.arm = a; bus.start = s;
        @(posedge clk); @(negedge clk);
        bus.arm = 1'b0; bus.start = 1'b0;
        l = 0;
        while (!bus.done && l < 40) begin
            @(posedge clk); l++; @(negedge clk);
        end
        check({tag, "_done_seen"}, bus.done, 1'b1);
        $display("[TB] %s ships=%h prev=%h new=%h lat=%0d ok=%0b hit=%0b idx=%0d commit=%0b left=%0d live=%0b",
                 tag, sh, pv, nw, l, bus.ok, bus.hit, bus.shot_idx, bus.commit, bus.ships_left, bus.live);
    endtask

    // Check results on the done cycle, then that done/commit drop and results hold next cycle.
    task automatic expect_res(input string tag, input int l, input bit may_abort,
                              input bit e_ok, input bit e_hit, input bit e_commit,
                              input int e_left);
`ifdef SHOT_RESOLVER_EARLY_ABORT_EN
        if (may_abort) check({tag, "_lat_max"}, (l >= 2 && l <= 16), 1'b1);
        else           check({tag, "_lat"}, l, 16);
`else
        check({tag, "_lat"}, l, 16);
`endif
        check({tag, "_ok"}, bus.ok, e_ok);
        check({tag, "_hit"}, bus.hit, e_hit);
        check({tag, "_commit"}, bus.commit, e_commit);
        check({tag, "_left"}, bus.ships_left, e_left);
        check({tag, "_live"}, bus.live, (e_left != 0));
        @(negedge clk);
        check({tag, "_done_drop"}, bus.done, 1'b0);
        check({tag, "_commit_drop"}, bus.commit, 1'b0);
        check({tag, "_ok_hold"}, bus.ok, e_ok);
        check({tag, "_left_hold"}, bus.ships_left, e_left);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check({tag, "_no_done"}, seen, 0);
    endtask

    initial begin
        bus.arm = 1'b0; bus.start = 1'b0;
        bus.ships = '0; bus.shots_prev = '0; bus.shots_new = '0;
        repeat (2) @(negedge clk);

        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_ok", bus.ok, 1'b0);
        check("rst_hit", bus.hit, 1'b0);
        check("rst_commit", bus.commit, 1'b0);
        check("rst_shot_idx", bus.shot_idx, 0);
        check("rst_left", bus.ships_left, 0);
        check("rst_live", bus.live, 1'b0);
        clr = 1'b0;
        @(negedge clk);

        do_op("arm_f3", 1, 0, 16'h00F3, 16'h0000, 16'h0000, lat);
        expect_res("arm_f3", lat, 0, 1, 0, 0, 6);

        do_op("hit1", 0, 1, 16'h00F3, 16'h0000, 16'h0002, lat);
        check("hit1_idx", bus.shot_idx, 1);
        expect_res("hit1", lat, 0, 1, 1, 1, 5);

        do_op("miss10", 0, 1, 16'h00F3, 16'h0002, 16'h0402, lat);
        check("miss10_idx", bus.shot_idx, 10);
        expect_res("miss10", lat, 0, 1, 0, 1, 5);

        do_op("same", 0, 1, 16'h00F3, 16'h0402, 16'h0402, lat);
        expect_res("same", lat, 0, 0, 0, 0, 5);

        do_op("two_bits", 0, 1, 16'h00F3, 16'h0002, 16'h0403, lat);
        expect_res("two_bits", lat, 1, 0, 0, 0, 5);

        do_op("removed", 0, 1, 16'h00F3, 16'h0002, 16'h0000, lat);
        expect_res("removed", lat, 1, 0, 0, 0, 5);

        // start pulsed mid-scan must be dropped: exactly one done follows
        bus.ships = 16'h00F3; bus.shots_prev = 16'h0402; bus.shots_new = 16'h0C02;
        bus.start = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
        check("busy_start_done", bus.done, 1'b1);
        check("busy_start_idx", bus.shot_idx, 11);
        check("busy_start_ok", bus.ok, 1'b1);
        $display("[TB] start_during_busy ok=%0b idx=%0d left=%0d", bus.ok, bus.shot_idx, bus.ships_left);
        watch_no_done("busy_start", 20);

        // arm and start together: arm wins, start is dropped
        do_op("arm_start", 1, 1, 16'h0001, 16'h0000, 16'h0002, lat);
        expect_res("arm_start", lat, 0, 1, 0, 0, 1);
        watch_no_done("arm_start", 20);

        do_op("sink", 0, 1, 16'h0001, 16'h0000, 16'h0001, lat);
        check("sink_idx", bus.shot_idx, 0);
        expect_res("sink", lat, 0, 1, 1, 1, 0);

        do_op("after_sink_miss", 0, 1, 16'h0001, 16'h0001, 16'h0005, lat);
        expect_res("after_sink_miss", lat, 0, 1, 0, 1, 0);

        do_op("hit_at_zero", 0, 1, 16'h0003, 16'h0001, 16'h0003, lat);
        expect_res("hit_at_zero", lat, 0, 1, 1, 1, 0);

        do_op("arm_empty", 1, 0, 16'h0000, 16'h0000, 16'h0000, lat);
        expect_res("arm_empty", lat, 0, 1, 0, 0, 0);

        do_op("arm_0f", 1, 0, 16'h000F, 16'h0000, 16'h0000, lat);
        expect_res("arm_0f", lat, 0, 1, 0, 0, 4);

        // clr at scan cycle 7 aborts everything
        bus.ships = 16'h00FF; bus.arm = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.arm = 1'b0;
        repeat (6) @(negedge clk);
        check("clr_pre_busy", bus.busy, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", bus.busy, 1'b0);
        check("clr_left", bus.ships_left, 0);
        check("clr_live", bus.live, 1'b0);
        check("clr_ok", bus.ok, 1'b0);
        $display("[TB] clr_mid_scan busy=%0b left=%0d", bus.busy, bus.ships_left);
        watch_no_done("clr", 20);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
